turfio_word_assembler: RTL and testbench

//  Downstream of the RXCLK->ACLK nibble transfer stage. Consumes the 4-bit nibble stream and its CE (1 per 3 aclk),

---
 rtl/turfio_pkg.sv | 21 ++
 rtl/turfio_ce_cadence_mon.sv | 58 +++++
 rtl/turfio_word_assembler.sv | 155 +++++++++++++++
 tb/tb_turfio_word_assembler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turfio_pkg.sv
// -----------------------------------------------------------------------------
// turfio_pkg
// Shared types and default constants for the TURFIO word assembler.
//   assembler_state_t   : alignment FSM states (HUNT, CHECK, LOCKED)
//   TRAIN_PATTERN_DEF   : default training word that marks the word boundary
//   CE_PERIOD_DEF       : default aclk cycles between nibble CEs
//   NIBBLES_PER_WORD    : nibbles assembled into one 32-bit word
// -----------------------------------------------------------------------------
package turfio_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } assembler_state_t;

  localparam logic [31:0] TRAIN_PATTERN_DEF = 32'hA55A6996;
  localparam int          CE_PERIOD_DEF     = 3;
  localparam int          NIBBLES_PER_WORD  = 8;

endpackage

// File: rtl/turfio_ce_cadence_mon.sv
// -----------------------------------------------------------------------------
// turfio_ce_cadence_mon
// Watches the spacing of data_ce_i pulses and flags cadence violations.
//   aclk_i     in  : block clock
//   aresetn_i  in  : asynchronous active-low reset
//   data_ce_i  in  : nibble valid strobe from the transfer stage
//   ce_err_o   out : 1-cycle registered strobe on a cadence violation
// A CE arriving early (gap < CE_PERIOD) is flagged. A late CE is flagged
// once, at the moment the gap reaches CE_PERIOD+1, so the CE that finally
// ends the timed-out gap is not flagged a second time.
// -----------------------------------------------------------------------------
module turfio_ce_cadence_mon
  import turfio_pkg::*;
#(
  parameter int CE_PERIOD = CE_PERIOD_DEF
) (
  input  logic aclk_i,
  input  logic aresetn_i,
  input  logic data_ce_i,
  output logic ce_err_o
);

  localparam int             GW  = $clog2(CE_PERIOD + 2);
  localparam logic [GW-1:0]  PER = GW'(CE_PERIOD);
  localparam logic [GW-1:0]  SAT = GW'(CE_PERIOD + 1);

  // gap_q == 0 means no CE seen since reset, so the first CE is never judged.
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    gap_d = gap_q;
    err_d = 1'b0;
    if (data_ce_i) begin
      gap_d = GW'(1);
      // A gap of CE_PERIOD is correct; CE_PERIOD+1 was already flagged on timeout.
      if (gap_q != '0 && gap_q < PER) err_d = 1'b1;
    end else if (gap_q != '0 && gap_q != SAT) begin
      gap_d = gap_q + 1'b1;
      if (gap_q == PER) err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      gap_q <= '0;
      err_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      err_q <= err_d;
    end
  end

  assign ce_err_o = err_q;

endmodule

// File: rtl/turfio_word_assembler.sv
// -----------------------------------------------------------------------------
// turfio_word_assembler
// Assembles the 4-bit nibble stream into 32-bit words (MSB nibble first),
// finds word alignment against a training pattern and counts link errors.
//   aclk_i, aresetn_i   : clock, asynchronous active-low reset
//   data_i, data_ce_i   : nibble and its valid strobe
//   capture_err_i       : upstream capture error flag (counted)
//   train_en_i          : link is sending TRAIN_PATTERN; enables hunt/check
//   realign_i           : drop lock and re-hunt (overrides everything else)
//   err_clear_i         : zero the error counter
//   word_o/word_valid_o : assembled word and its 1-cycle strobe (locked only)
//   locked_o            : alignment established
//   ce_err_o            : CE cadence violation strobe
//   err_count_o         : saturating count of error cycles
// -----------------------------------------------------------------------------
module turfio_word_assembler
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int          LOCK_COUNT    = 4,
  parameter int          CE_PERIOD     = CE_PERIOD_DEF,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  input  logic [3:0]               data_i,
  input  logic                     data_ce_i,
  input  logic                     capture_err_i,
  input  logic                     train_en_i,
  input  logic                     realign_i,
  input  logic                     err_clear_i,
  output logic [31:0]              word_o,
  output logic                     word_valid_o,
  output logic                     locked_o,
  output logic                     ce_err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  assembler_state_t         state_q, state_d;
  logic [31:0]              sreg_q, sreg_d;
  logic [2:0]               nib_cnt_q, nib_cnt_d;
  logic [MW-1:0]            match_q, match_d, match_inc;
  logic [31:0]              word_q, word_d;
  logic                     valid_q, valid_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     word_done;
  logic                     lock_loss;
  logic                     ce_err;

  turfio_ce_cadence_mon #(
    .CE_PERIOD (CE_PERIOD)
  ) u_cadence (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .data_ce_i (data_ce_i),
    .ce_err_o  (ce_err)
  );

  // Comparisons use the post-shift value so the nibble arriving this cycle counts.
  assign sreg_d    = data_ce_i ? {sreg_q[27:0], data_i} : sreg_q;
  assign word_done = data_ce_i && (nib_cnt_q == 3'd7);
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = data_ce_i ? nib_cnt_q + 1'b1 : nib_cnt_q;
    match_d   = match_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    lock_loss = 1'b0;

    if (realign_i) begin
      state_d   = HUNT;
      nib_cnt_d = '0;
      match_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          // Sliding search: any CE may mark the end of a training word.
          if (train_en_i && data_ce_i && sreg_d == TRAIN_PATTERN) begin
            nib_cnt_d = '0;
            match_d   = MW'(1);
            state_d   = (LOCK_COUNT == 1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (!train_en_i) begin
            state_d = HUNT;
            match_d = '0;
          end else if (word_done) begin
            if (sreg_d == TRAIN_PATTERN) begin
              match_d = match_inc;
              if (match_inc == MW'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              state_d = HUNT;
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (word_done) begin
            valid_d = 1'b1;
            word_d  = sreg_d;
            // The mismatching word is still delivered; only the lock is dropped.
            if (train_en_i && sreg_d != TRAIN_PATTERN) begin
              state_d   = HUNT;
              match_d   = '0;
              lock_loss = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Clear beats increment; several simultaneous error sources count once.
  always_comb begin
    err_d = err_q;
    if (err_clear_i) begin
      err_d = '0;
    end else if ((capture_err_i || ce_err || lock_loss) && err_q != '1) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= HUNT;
      sreg_q    <= '0;
      nib_cnt_q <= '0;
      match_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      nib_cnt_q <= nib_cnt_d;
      match_q   <= match_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign locked_o     = (state_q == LOCKED);
  assign ce_err_o     = ce_err;
  assign err_count_o  = err_q;

endmodule

// File: tb/tb_turfio_word_assembler.sv
// -----------------------------------------------------------------------------
// tb_turfio_word_assembler
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model built from nibble history, CE timestamps and
// plain integer counters.
// -----------------------------------------------------------------------------
module tb_turfio_word_assembler;

  localparam logic [31:0] PAT     = 32'hA55A6996;
  localparam int          LC      = 4;
  localparam int          PER     = 3;
  localparam int          EW      = 5;
  localparam int          ERR_MAX = (1 << EW) - 1;

  logic          aclk;
  logic          aresetn;
  logic [3:0]    data_i;
  logic          data_ce_i;
  logic          capture_err_i;
  logic          train_en_i;
  logic          realign_i;
  logic          err_clear_i;
  logic [31:0]   word_o;
  logic          word_valid_o;
  logic          locked_o;
  logic          ce_err_o;
  logic [EW-1:0] err_count_o;

  turfio_word_assembler #(
    .TRAIN_PATTERN (PAT),
    .LOCK_COUNT    (LC),
    .CE_PERIOD     (PER),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .aclk_i        (aclk),
    .aresetn_i     (aresetn),
    .data_i        (data_i),
    .data_ce_i     (data_ce_i),
    .capture_err_i (capture_err_i),
    .train_en_i    (train_en_i),
    .realign_i     (realign_i),
    .err_clear_i   (err_clear_i),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .locked_o      (locked_o),
    .ce_err_o      (ce_err_o),
    .err_count_o   (err_count_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  nibq[$];
  int          cyc, last_ce;
  bit          have_ce;
  bit          m_ce_err, m_locked, m_valid;
  int          m_matches, m_phase, m_err;
  logic [31:0] m_word;

  // Observations of the DUT used for scenario-level checks.
  int          n_strobes, n_ce_err;
  logic [31:0] last_word;

  function automatic logic [31:0] window_value();
    logic [31:0] v = '0;
    foreach (nibq[i]) v = (v << 4) | 32'(nibq[i]);
    return v;
  endfunction

  task automatic model_reset();
    nibq.delete();
    cyc = 0; last_ce = 0; have_ce = 0;
    m_ce_err = 0; m_locked = 0; m_valid = 0;
    m_matches = 0; m_phase = 0; m_err = 0; m_word = '0;
  endtask

  task automatic model_step();
    bit          ce_flag   = 0;
    bit          lockloss  = 0;
    bit          word_end  = 0;
    bit          err_seen  = m_ce_err;
    logic [31:0] w         = window_value();
    if (data_ce_i) begin
      if (have_ce && (cyc - last_ce) < PER) ce_flag = 1;
      have_ce = 1;
      last_ce = cyc;
    end else if (have_ce && (cyc - last_ce) == PER) begin
      ce_flag = 1;
    end
    m_valid = 0;
    if (data_ce_i) begin
      nibq.push_back(data_i);
      if (nibq.size() > 8) void'(nibq.pop_front());
      w        = window_value();
      word_end = (m_phase == 7);
      m_phase  = (m_phase + 1) % 8;
    end
    if (realign_i) begin
      m_locked = 0; m_matches = 0; m_phase = 0;
    end else if (m_locked) begin
      if (word_end) begin
        m_valid = 1;
        m_word  = w;
        if (train_en_i && w != PAT) begin
          m_locked = 0; m_matches = 0; lockloss = 1;
        end
      end
    end else if (m_matches > 0) begin
      if (!train_en_i) m_matches = 0;
      else if (word_end) begin
        if (w == PAT) begin
          m_matches++;
          if (m_matches == LC) m_locked = 1;
        end else m_matches = 0;
      end
    end else if (train_en_i && data_ce_i && w == PAT) begin
      m_phase = 0; m_matches = 1;
      if (LC == 1) m_locked = 1;
    end
    if (err_clear_i) m_err = 0;
    else if ((capture_err_i || err_seen || lockloss) && m_err < ERR_MAX) m_err++;
    m_ce_err = ce_flag;
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge aclk);
    model_step();
    #1;
    check("word_valid", word_valid_o, m_valid);
    check("locked", locked_o, m_locked);
    check("ce_err", ce_err_o, m_ce_err);
    check("err_count", err_count_o, m_err);
    check("word", word_o, m_word);
    if (word_valid_o) begin n_strobes++; last_word = word_o; end
    if (ce_err_o) n_ce_err++;
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap, input bit rl);
    data_i = n; data_ce_i = 1'b1; realign_i = rl;
    step();
    data_ce_i = 1'b0; realign_i = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_nib(w[4*i +: 4], PER, 1'b0);
  endtask

  task automatic hold_reset();
    aresetn = 1'b0;
    data_ce_i = 0; capture_err_i = 0; realign_i = 0; err_clear_i = 0; data_i = '0;
    #1;
    model_reset();
    check("rst_word", word_o, 32'h0);
    check("rst_valid", word_valid_o, 1'b0);
    check("rst_locked", locked_o, 1'b0);
    check("rst_ce_err", ce_err_o, 1'b0);
    check("rst_err_count", err_count_o, '0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    n_strobes = 0; n_ce_err = 0; last_word = '0;
  endtask

  logic [31:0] src_word;
  int          nib_idx, gap_left, s0, r;

  initial begin
    aresetn = 1'b0; data_i = '0; data_ce_i = 0; capture_err_i = 0;
    train_en_i = 0; realign_i = 0; err_clear_i = 0;
    #12;
    hold_reset();

    // 1: aligned training stream locks after four words.
    train_en_i = 1'b1;
    repeat (3) send_word(PAT);
    check("t1_not_locked_yet", locked_o, 1'b0);
    send_word(PAT);
    check("t1_locked", locked_o, 1'b1);
    check("t1_err_zero", err_count_o, '0);
    send_word(PAT);
    check("t1_word", word_o, PAT);
    check("t1_strobes", n_strobes, 1);

    // 2: three garbage nibbles, then hunt and lock; user word with train_en low.
    hold_reset();
    train_en_i = 1'b1;
    send_nib(4'h1, PER, 1'b0);
    send_nib(4'h2, PER, 1'b0);
    send_nib(4'h3, PER, 1'b0);
    repeat (4) send_word(PAT);
    check("t2_locked", locked_o, 1'b1);
    train_en_i = 1'b0;
    send_word(32'h12345678);
    check("t2_user_word", last_word, 32'h12345678);
    check("t2_user_strobe", n_strobes, 1);

    // 3: corrupted training word drops lock, is still delivered, then relock.
    train_en_i = 1'b1;
    send_word(PAT);
    send_word(32'hA55A6997);
    check("t3_bad_word", last_word, 32'hA55A6997);
    check("t3_unlocked", locked_o, 1'b0);
    check("t3_err_one", err_count_o, 1);
    repeat (5) send_word(PAT);
    check("t3_relocked", locked_o, 1'b1);

    // 6: realign on the 8th CE suppresses the strobe; then reset mid-word.
    s0 = n_strobes;
    for (int i = 7; i >= 1; i--) send_nib(PAT[4*i +: 4], PER, 1'b0);
    send_nib(PAT[3:0], PER, 1'b1);
    check("t6_no_strobe", n_strobes, s0);
    check("t6_unlocked", locked_o, 1'b0);
    send_nib(4'hA, PER, 1'b0);
    send_nib(4'h5, 1, 1'b0);
    #3;
    hold_reset();

    // 4: CE gaps 3,3,2,3,5 give two cadence errors; capture_err adds three.
    train_en_i = 1'b0;
    send_nib(4'h0, 3, 1'b0);
    send_nib(4'h1, 3, 1'b0);
    send_nib(4'h2, 2, 1'b0);
    send_nib(4'h3, 3, 1'b0);
    send_nib(4'h4, 5, 1'b0);
    send_nib(4'h5, 3, 1'b0);
    send_nib(4'h6, 3, 1'b0);
    check("t4_ce_pulses", n_ce_err, 2);
    check("t4_err_two", err_count_o, 2);
    capture_err_i = 1'b1;
    send_nib(4'h7, 3, 1'b0);
    capture_err_i = 1'b0;
    send_nib(4'h8, 3, 1'b0);
    check("t4_err_five", err_count_o, 5);

    // 5: saturation, then clear wins over a simultaneous increment.
    hold_reset();
    capture_err_i = 1'b1;
    repeat (ERR_MAX + 8) step();
    check("t5_saturated", err_count_o, ERR_MAX);
    err_clear_i = 1'b1;
    step();
    check("t5_cleared", err_count_o, '0);
    err_clear_i = 1'b0; capture_err_i = 1'b0;
    step();

    // Randomized traffic: mostly training words, some corrupted, slips and odd gaps.
    hold_reset();
    nib_idx = 8; gap_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (gap_left == 0) begin
        if (nib_idx == 8) begin
          r = $urandom_range(0, 19);
          if (r < 14)      src_word = PAT;
          else if (r < 17) src_word = PAT ^ (32'h1 << $urandom_range(0, 31));
          else             src_word = $urandom;
          train_en_i = ($urandom_range(0, 9) != 0);
          nib_idx = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 7) : 0;
        end
        data_i    = src_word[4*(7-nib_idx) +: 4];
        nib_idx++;
        data_ce_i = 1'b1;
        gap_left  = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 6) : PER;
      end else begin
        data_ce_i = 1'b0;
      end
      gap_left--;
      capture_err_i = ($urandom_range(0, 49) == 0);
      realign_i     = ($urandom_range(0, 199) == 0);
      err_clear_i   = ($urandom_range(0, 99) == 0);
      step();
    end
    data_ce_i = 0; capture_err_i = 0; realign_i = 0; err_clear_i = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
